io_input_port: RTL and testbench
================================

# io_input_port

Memory-mapped input peripheral feeding the CPU load path: debounces the confirmation button, synchronises the 16 switches, and captures a switch snapshot on each debounced press. Exposes the captured value and a valid/overrun status word at fixed I/O addresses. Forms the input half of the I/O subsystem, complementing the segment-display write port at 0xFFFF_FFF0.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronised cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- switchInput  in  16  raw slide switches, asynchronous to clk.
- confirmation  in  1  raw push button, asynchronous, bouncing; 1 = pressed.
- address  in  32  CPU load/store address.
- readEnable  in  1  CPU load strobe, one cycle per load.
- dataIOInput  out  32  read data for the current address (combinational).
- inputValid  out  1  captured value not yet consumed (mirrors status bit 0).

## Operation
- Synchronisers: switchInput and confirmation each pass through two flops (sw_s2, btn_s2).
- Debounce FSM, states RELEASED / PRESSED (register stable, reset RELEASED):
  - counter clears whenever btn_s2 equals the current state's level.
  - counter increments each cycle btn_s2 differs; on the edge where it reaches DEBOUNCE_CYCLES-1, the state flips and counter clears.
  - RELEASED→PRESSED is a press event; PRESSED→RELEASED has no side effect.
- Press event: dataReg ← sw_s2; valid ← 1; overrun ← 1 if valid was already 1.
- Address map (dataIOInput):
  - 0xFFFF_FFF4 → {16'h0000, dataReg}.
  - 0xFFFF_FFF8 → {30'b0, overrun, valid}.
  - any other address → 32'h0000_0000.
- Consume: readEnable with address 0xFFFF_FFF4 clears valid and overrun on that edge. Status reads have no side effect. readEnable at other addresses is ignored.
- Simultaneous consume and press event on one edge: dataReg takes the new snapshot, valid = 1, overrun = 0.
- dataReg is held until the next press event. Switch changes without a press are not captured.

## Timing
- Reset values: state RELEASED, counter 0, synchroniser flops 0, dataReg 16'h0000, valid 0, overrun 0. Hence inputValid 0, and dataIOInput is 0 at every address.
- Press latency: a clean raw 0→1 at cycle edge N sets valid at edge N+1+DEBOUNCE_CYCLES (2 synchroniser edges plus DEBOUNCE_CYCLES-1 counting edges, minus overlap); it is visible on outputs immediately after that edge.
- Glitch rejection: any btn_s2 pulse shorter than DEBOUNCE_CYCLES cycles produces no state change; the counter restarts at 0 on return.
- Holding the button produces exactly one event. A new event requires a debounced release followed by a debounced press.
- Reads are combinational: data returned the same cycle as address; clearing takes effect the following cycle.
- Reset asserted mid-count or mid-press returns all state to reset values asynchronously. After release, a still-held button counts as a new press once debounced.

## Test plan
- Reset: rst=0 with random inputs → inputValid=0; reads of 0xFFFF_FFF4, 0xFFFF_FFF8 and 0xFFFF_FFF0 all return 0.
- Clean press (DEBOUNCE_CYCLES=4): switchInput=16'hA5C3, confirmation 0→1 at edge N and held → inputValid=1 at edge N+5; read 0xFFFF_FFF4 returns 32'h0000_A5C3; after the read, status reads 0.
- Bounce: confirmation pulses of 1, 2 and 3 cycles separated by 1-cycle lows → no event. Final steady high → exactly one event, DEBOUNCE_CYCLES+2 edges after the final rise.
- Overrun: two debounced presses (switches 16'h0001, then 16'h0002) with no data read → status 32'h3, data 32'h0000_0002; one data read → status 32'h0.
- Simultaneous event: data read on the same edge as a press event with switches 16'hBEEF → status 32'h1 and data 32'h0000_BEEF next cycle.
- Reset mid-debounce: rst pulsed low at counter=2 with the button held → no event until DEBOUNCE_CYCLES+2 edges after rst returns high, then valid=1.

Source files
------------

// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronises switches, debounces the confirm button and
// captures a switch snapshot per debounced press, readable with valid/overrun status.
module io_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switchInput,
  input  logic        confirmation,
  input  logic [31:0] address,
  input  logic        readEnable,
  output logic [31:0] dataIOInput,
  output logic        inputValid
);

  localparam logic [31:0]      ADDR_DATA = 32'hFFFF_FFF4;
  localparam logic [31:0]      ADDR_STAT = 32'hFFFF_FFF8;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StReleased, StPressed} btn_state_e;

  btn_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [15:0]      r_sw_s1, r_sw_s2, r_data;
  logic             r_btn_s1, r_btn_s2;
  logic             r_valid, r_overrun;
  logic             w_level, w_press, w_consume;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= switchInput;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= confirmation;
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_level = (r_state == StPressed);

  // Counter tracks consecutive synchronised samples that disagree with the debounced level.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_press      = 1'b0;
    if (r_btn_s2 != w_level) begin
      if (r_cnt == CNT_LAST) begin
        w_state_next = w_level ? StReleased : StPressed;
        w_press      = !w_level;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StReleased;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_consume = readEnable && (address == ADDR_DATA);

  // A press wins over a same-edge consume: the fresh snapshot stays valid, overrun clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_press) begin
      r_data    <= r_sw_s2;
      r_valid   <= 1'b1;
      r_overrun <= r_valid && !w_consume;
    end else if (w_consume) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  always_comb begin
    dataIOInput = 32'h0000_0000;
    if (address == ADDR_DATA) begin
      dataIOInput = {16'h0000, r_data};
    end else if (address == ADDR_STAT) begin
      dataIOInput = {30'b0, r_overrun, r_valid};
    end
  end

  assign inputValid = r_valid;

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed corner cases, an address-decode table and a
// randomized run checked against a sample-window reference model.
module tb_io_input_port;

  localparam int unsigned D = 4;
  localparam logic [31:0] A_DATA = 32'hFFFF_FFF4;
  localparam logic [31:0] A_STAT = 32'hFFFF_FFF8;
  localparam logic [31:0] A_SEG  = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switchInput;
  logic        confirmation;
  logic [31:0] address;
  logic        readEnable;
  logic [31:0] dataIOInput;
  logic        inputValid;

  int total = 0;
  int bad   = 0;

  io_input_port #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .switchInput (switchInput),
    .confirmation(confirmation),
    .address     (address),
    .readEnable  (readEnable),
    .dataIOInput (dataIOInput),
    .inputValid  (inputValid)
  );

  always #5 clk = ~clk;

  // Reference model: raw inputs reach the debouncer two edges late; the debounced
  // level flips once the last D delayed button samples all disagree with it.
  logic [16:0] m_pipe[$] = {17'd0, 17'd0};
  logic        m_win[$];
  logic        m_pressed = 1'b0;
  logic        m_valid   = 1'b0;
  logic        m_overrun = 1'b0;
  logic [15:0] m_data    = 16'h0;

  always @(posedge clk or negedge rst) begin
    logic [16:0] s;
    logic        all_diff;
    logic        press;
    logic        consume;
    if (!rst) begin
      m_pipe    = {17'd0, 17'd0};
      m_win     = {};
      m_pressed = 1'b0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_data    = 16'h0;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back({confirmation, switchInput});
      consume = readEnable && (address == A_DATA);
      m_win.push_back(s[16]);
      if (m_win.size() > D) void'(m_win.pop_front());
      all_diff = (m_win.size() == D);
      foreach (m_win[i]) if (m_win[i] == m_pressed) all_diff = 1'b0;
      press = 1'b0;
      if (all_diff) begin
        m_pressed = !m_pressed;
        press     = m_pressed;
      end
      if (press) begin
        m_data    = s[15:0];
        m_overrun = (m_overrun | m_valid) & !consume;
        m_valid   = 1'b1;
      end else if (consume) begin
        m_valid   = 1'b0;
        m_overrun = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_read(logic [31:0] a);
    if (a == A_DATA) return {16'h0000, m_data};
    if (a == A_STAT) return {30'b0, m_overrun, m_valid};
    return 32'h0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has just raised the button; the event must land D+2 edges later.
  task automatic press_latency(string nm);
    int seen = 0;
    for (int k = 1; k <= int'(D) + 4; k++) begin
      tick();
      if (inputValid && seen == 0) seen = k;
    end
    chk(nm, seen, D + 2);
  endtask

  task automatic release_btn();
    confirmation = 1'b0;
    repeat (D + 3) tick();
  endtask

  task automatic consume();
    address    = A_DATA;
    readEnable = 1'b1;
    tick();
    readEnable = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[7];
  int      pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 0};
  logic    any_valid;
  int      run;

  initial begin
    tbl[0] = '{A_DATA,        32'h0000_A5C3};
    tbl[1] = '{A_STAT,        32'h0000_0001};
    tbl[2] = '{A_SEG,         32'h0000_0000};
    tbl[3] = '{32'hFFFF_FFFC, 32'h0000_0000};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000};
    tbl[5] = '{32'h7FFF_FFF4, 32'h0000_0000};
    tbl[6] = '{32'hFFFF_FFF5, 32'h0000_0000};

    // Reset with random activity on the inputs
    rst          = 1'b0;
    switchInput  = 16'($urandom);
    confirmation = 1'b1;
    address      = A_DATA;
    readEnable   = 1'b1;
    repeat (3) begin
      tick();
      switchInput  = 16'($urandom);
      confirmation = 1'($urandom);
    end
    chk("reset_valid", inputValid, 0);
    address = A_DATA; #1; chk("reset_rd_data", dataIOInput, 0);
    address = A_STAT; #1; chk("reset_rd_stat", dataIOInput, 0);
    address = A_SEG;  #1; chk("reset_rd_seg", dataIOInput, 0);
    readEnable   = 1'b0;
    confirmation = 1'b0;
    address      = 32'h0;
    rst          = 1'b1;
    repeat (D + 3) tick();

    // Clean press
    switchInput  = 16'hA5C3;
    repeat (3) tick();
    confirmation = 1'b1;
    press_latency("clean_latency");
    for (int i = 0; i < 7; i++) begin
      address = tbl[i].addr;
      #1;
      chk($sformatf("read_tbl[%0d]", i), dataIOInput, tbl[i].exp);
    end
    consume();
    address = A_STAT; #1; chk("clean_stat_after_read", dataIOInput, 0);
    chk("clean_valid_after_read", inputValid, 0);
    address = A_DATA; #1; chk("clean_data_held", dataIOInput, 32'h0000_A5C3);
    repeat (D + 4) tick();
    chk("hold_single_event", inputValid, 0);

    // Bounce: short pulses must not register
    release_btn();
    any_valid = 1'b0;
    foreach (pat[i]) begin
      confirmation = pat[i][0];
      tick();
      any_valid |= inputValid;
    end
    chk("bounce_no_event", any_valid, 0);
    confirmation = 1'b1;
    press_latency("bounce_final_latency");
    consume();

    // Overrun: two presses without a read
    release_btn();
    switchInput  = 16'h0001;
    confirmation = 1'b1;
    repeat (D + 4) tick();
    switchInput  = 16'h0002;
    release_btn();
    confirmation = 1'b1;
    repeat (D + 4) tick();
    address = A_STAT; #1; chk("overrun_stat", dataIOInput, 32'h3);
    address = A_DATA; #1; chk("overrun_data", dataIOInput, 32'h0000_0002);
    consume();
    address = A_STAT; #1; chk("overrun_cleared", dataIOInput, 32'h0);

    // Press on the same edge as a data read, with a pending unread value
    release_btn();
    switchInput  = 16'h1234;
    confirmation = 1'b1;
    repeat (D + 4) tick();
    release_btn();
    switchInput  = 16'hBEEF;
    confirmation = 1'b1;
    repeat (D + 1) tick();
    consume();
    address = A_STAT; #1; chk("simul_stat", dataIOInput, 32'h1);
    address = A_DATA; #1; chk("simul_data", dataIOInput, 32'h0000_BEEF);

    // Reset mid-debounce with the button held
    release_btn();
    confirmation = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", inputValid, 0);
    address = A_DATA; #0; chk("rst_mid_data", dataIOInput, 0);
    rst = 1'b1;
    press_latency("rst_mid_latency");

    // Randomized run against the model
    release_btn();
    run = 0;
    for (int c = 0; c < 600; c++) begin
      if (run == 0) begin
        confirmation = 1'($urandom_range(0, 1));
        run          = $urandom_range(1, 10);
      end
      run--;
      readEnable = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       address = A_DATA;
        1:       address = A_STAT;
        2:       address = A_SEG;
        default: address = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) switchInput = 16'($urandom);
      tick();
      chk("rnd_valid", inputValid, m_valid);
      chk("rnd_read", dataIOInput, exp_read(address));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
